// File: rtl/multiplier_4bits_version15.sv
// multiplier_4bits_version15: registered unsigned 4x4 -> 8 structural array multiplier
// Ports: clk (rising edge), rst (sync, active high), A/B (4-bit operands), product (8-bit A*B, registered)
// Build option MULT4_INPUT_REG_EN: registers A and B ahead of the array (latency 2 instead of 1)

module multiplier_4bits_version15_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module multiplier_4bits_version15_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ ci_i;
    assign c_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module multiplier_4bits_version15 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] product
);
    logic [3:0] a_w, b_w;
`ifdef MULT4_INPUT_REG_EN
    logic [3:0] a_q, b_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 4'h0;
            b_q <= 4'h0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end
    assign a_w = a_q;
    assign b_w = b_q;
`else
    assign a_w = A;
    assign b_w = B;
`endif
    // pp[i][j] = A[j] & B[i], weight 2^(i+j)
    logic [3:0] pp [4];
    for (genvar i = 0; i < 4; i++) begin : g_pp
        assign pp[i] = a_w & {4{b_w[i]}};
    end
    // Stage 1 brings columns 3 and 4 down to three bits
    logic s1, c1, s2, c2;
    multiplier_4bits_version15_ha u_ha1 (.a_i(pp[0][3]), .b_i(pp[1][2]), .s_o(s1), .c_o(c1));
    multiplier_4bits_version15_ha u_ha2 (.a_i(pp[1][3]), .b_i(pp[2][2]), .s_o(s2), .c_o(c2));
    // Stage 2 brings every column down to two bits
    logic s3, c3, s4, c4, s5, c5, s6, c6;
    multiplier_4bits_version15_ha u_ha3 (.a_i(pp[0][2]), .b_i(pp[1][1]), .s_o(s3), .c_o(c3));
    multiplier_4bits_version15_fa u_fa1 (.a_i(s1), .b_i(pp[2][1]), .ci_i(pp[3][0]), .s_o(s4), .c_o(c4));
    multiplier_4bits_version15_fa u_fa2 (.a_i(s2), .b_i(pp[3][1]), .ci_i(c1), .s_o(s5), .c_o(c5));
    multiplier_4bits_version15_fa u_fa3 (.a_i(pp[2][3]), .b_i(pp[3][2]), .ci_i(c2), .s_o(s6), .c_o(c6));
    // Two rows over columns 1..6, index 0 is column 1
    logic [5:0] x, y, rc;
    logic [7:0] product_d, product_q;
    assign x = {pp[3][3], s6, s5, s4, s3, pp[0][1]};
    assign y = {c6, c5, c4, c3, pp[2][0], pp[1][0]};
    assign product_d[0] = pp[0][0];
    multiplier_4bits_version15_ha u_rc0 (.a_i(x[0]), .b_i(y[0]), .s_o(product_d[1]), .c_o(rc[0]));
    for (genvar g = 1; g < 6; g++) begin : g_rc
        multiplier_4bits_version15_fa u_rc (
            .a_i(x[g]), .b_i(y[g]), .ci_i(rc[g-1]), .s_o(product_d[g+1]), .c_o(rc[g])
        );
    end
    assign product_d[7] = rc[5];
    always_ff @(posedge clk) begin
        if (rst) product_q <= 8'h00;
        else     product_q <= product_d;
    end
    assign product = product_q;
endmodule

// File: tb/tb_multiplier_4bits_version15.sv
// tb_multiplier_4bits_version15: vector table plus scoreboard check of the registered 4x4 multiplier
module tb_multiplier_4bits_version15;
`ifdef MULT4_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = 4'h0;
    logic [3:0] B = 4'h0;
    logic [7:0] product;

    multiplier_4bits_version15 dut (.clk(clk), .rst(rst), .A(A), .B(B), .product(product));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] exp_q [$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; reset wipes every result still in flight
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r, input logic [7:0] e);
        logic [7:0] want;
        @(negedge clk);
        A = a;
        B = b;
        rst = r;
        if (r) foreach (exp_q[k]) exp_q[k] = 8'h00;
        exp_q.push_back(r ? 8'h00 : e);
        @(posedge clk);
        #1;
        if (r) check("rst_zero", product, 8'h00);
        if (exp_q.size() >= LAT) begin
            want = exp_q.pop_front();
            check("scoreboard", product, want);
        end
    endtask

    initial begin
        tbl[0] = '{4'd2,  4'd3,  8'd6};
        tbl[1] = '{4'd10, 4'd3,  8'd30};
        tbl[2] = '{4'd13, 4'd10, 8'd130};
        tbl[3] = '{4'd0,  4'd9,  8'd0};
        tbl[4] = '{4'd1,  4'd9,  8'd9};
        tbl[5] = '{4'd15, 4'd1,  8'd15};
        tbl[6] = '{4'd8,  4'd8,  8'd64};
        tbl[7] = '{4'd15, 4'd15, 8'd225};
        for (int i = 0; i < 3; i++) step(4'd15, 4'd15, 1'b1, 8'd0);
        step(4'd15, 4'd15, 1'b0, 8'd225);
        for (int i = 0; i < 8; i++) step(tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp);
        for (int n = 0; n < 256; n++) begin
            logic [3:0] a, b;
            a = 4'(n >> 4);
            b = 4'(n);
            step(a, b, n == 100, 8'(a * b));
        end
        for (int i = 0; i < LAT; i++) step(4'd0, 4'd0, 1'b0, 8'd0);
        if (exp_q.size() != 0) check("drain", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
